// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver.
// The receiver uses the master view; the line driver and byte consumer use the slave view.
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       frame_err_out;
    logic       overrun_out;
    logic       busy_out;

    modport master (
        input  rx_in,
        input  ready_in,
        output data_out,
        output valid_out,
        output frame_err_out,
        output overrun_out,
        output busy_out
    );

    modport slave (
        output rx_in,
        output ready_in,
        input  data_out,
        input  valid_out,
        input  frame_err_out,
        input  overrun_out,
        input  busy_out
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// Flags framing errors (stop bit low) and overruns (byte dropped while one is unconsumed).
module uart_rx #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115_200
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    uart_rx_if.master bus
);
    localparam int unsigned CPB = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CW  = $clog2(CPB);

    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] SETTLE    = CW'(2);

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e        r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;
    logic          r_busy;
    logic          w_rxs;

    assign w_rxs = r_sync[1];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync      <= 2'b11;
            r_state     <= StWaitIdle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], bus.rx_in};
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_valid && bus.ready_in) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                // Three consecutive highs are required so the synchronizer's reset value
                // cannot be mistaken for an idle line when rx is held low at reset release.
                StWaitIdle: begin
                    if (w_rxs) begin
                        if (r_cnt == SETTLE) begin
                            r_state <= StIdle;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                StIdle: begin
                    if (!w_rxs) begin
                        r_state <= StStart;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state <= StData;
                            r_idx   <= '0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= StStop;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b0;
                        if (w_rxs) begin
                            // Return at mid-stop so a back-to-back start edge is caught.
                            r_state <= StIdle;
                            if (!r_valid || bus.ready_in) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= StWaitIdle;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StWaitIdle;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out      = r_data;
    assign bus.valid_out     = r_valid;
    assign bus.frame_err_out = r_frame_err;
    assign bus.overrun_out   = r_overrun;
    assign bus.busy_out      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against an
// event-level model (expected byte / framing error / overrun with arrival window).
module tb_uart_rx;
    localparam int unsigned CPB = 8;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_if u_if();

    uart_rx #(
        .CLK_FREQ_HZ(100_000_000),
        .BAUD_RATE  (12_500_000)
    ) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (u_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EvByte = 0, EvFerr = 1, EvOver = 2} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t exp_q[$];
    bit  pending = 1'b0;
    int  n_vec = 0, n_err = 0;
    int  n_loads = 0, n_fe = 0, n_ov = 0, n_vcyc = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic got_event(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: kind %0d data 0x%02h at cycle %0d, none expected",
                     int'(k), d, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", int'(k), int'(e.kind));
        if (e.kind == EvByte && k == EvByte) chk("event_data", int'(d), int'(e.data));
        n_vec++;
        if (cyc < e.t - 2 || cyc > e.t + 2) begin
            n_err++;
            $display("FAIL event_time: seen at cycle %0d, expected %0d +/-2", cyc, e.t);
        end
    endtask

    // Per-cycle compare against the expected-event queue and handshake rules.
    initial begin
        logic       pv, pr;
        logic [7:0] pd;
        bit         loaded;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b0;
                pd = 8'h00;
            end else begin
                loaded = u_if.valid_out && (!pv || pr);
                chk("err_exclusive", int'(u_if.frame_err_out && u_if.overrun_out), 0);
                if (u_if.frame_err_out) got_event(EvFerr, 8'h00);
                if (u_if.overrun_out) got_event(EvOver, 8'h00);
                if (loaded) got_event(EvByte, u_if.data_out);
                if (pv && !pr) chk("hold_valid", int'(u_if.valid_out), 1);
                if (!loaded) chk("data_stable", int'(u_if.data_out), int'(pd));
                if (exp_q.size() > 0 && cyc > exp_q[0].t + 2) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL missing_event: kind %0d data 0x%02h due cycle %0d, none by %0d",
                             int'(exp_q[0].kind), exp_q[0].data, exp_q[0].t, cyc);
                    void'(exp_q.pop_front());
                end
                n_loads += int'(loaded);
                n_fe    += int'(u_if.frame_err_out);
                n_ov    += int'(u_if.overrun_out);
                n_vcyc  += int'(u_if.valid_out);
                pv = u_if.valid_out;
                pr = u_if.ready_in;
                pd = u_if.data_out;
            end
        end
    end

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic bit_wait();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        u_if.rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ready_pulse();
        u_if.ready_in = 1'b1;
        @(posedge clk);
        #1;
        u_if.ready_in = 1'b0;
        pending = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra);
        ev_t e;
        u_if.rx_in = 1'b0;
        if (u_if.ready_in) pending = 1'b0;
        e.t    = cyc + LAT;
        e.data = b;
        if (!stop_ok) begin
            e.kind = EvFerr;
        end else if (pending) begin
            e.kind = EvOver;
        end else begin
            e.kind  = EvByte;
            pending = !u_if.ready_in;
        end
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            bit_wait();
            u_if.rx_in = b[i];
        end
        bit_wait();
        u_if.rx_in = stop_ok;
        if (!stop_ok) repeat (extra) bit_wait();
        bit_wait();
        u_if.rx_in = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int         l0, f0, o0, v0;
        logic [7:0] c3;
        c3 = 8'hC3;
        rst_n = 1'b0;
        u_if.rx_in = 1'b1;
        u_if.ready_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", int'(u_if.data_out), 0);
        chk("rst_valid", int'(u_if.valid_out), 0);
        chk("rst_ferr", int'(u_if.frame_err_out), 0);
        chk("rst_overrun", int'(u_if.overrun_out), 0);
        chk("rst_busy", int'(u_if.busy_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // 1: single frame, consumer always ready
        u_if.ready_in = 1'b1;
        l0 = n_loads; v0 = n_vcyc; f0 = n_fe; o0 = n_ov;
        send_frame(8'hA5, 1'b1, 0);
        idle(2 * CPB);
        chk("t1_loads", n_loads - l0, 1);
        chk("t1_valid_cycles", n_vcyc - v0, 1);
        chk("t1_data", int'(u_if.data_out), 'hA5);
        chk("t1_no_errors", (n_fe - f0) + (n_ov - o0), 0);
        chk("t1_busy_idle", int'(u_if.busy_out), 0);

        // 2: two-cycle glitch is rejected
        l0 = n_loads; f0 = n_fe; o0 = n_ov;
        u_if.rx_in = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        idle(3 * CPB);
        chk("t2_no_activity", (n_loads - l0) + (n_fe - f0) + (n_ov - o0), 0);
        chk("t2_busy", int'(u_if.busy_out), 0);

        // 3: framing error, line low 3 bit periods, then a good frame
        l0 = n_loads; f0 = n_fe;
        send_frame(8'h3C, 1'b0, 2);
        idle(2 * CPB);
        send_frame(8'h81, 1'b1, 0);
        idle(2 * CPB);
        chk("t3_ferr", n_fe - f0, 1);
        chk("t3_loads", n_loads - l0, 1);
        chk("t3_data", int'(u_if.data_out), 'h81);

        // 4: overrun while the first byte is held
        u_if.ready_in = 1'b0;
        o0 = n_ov;
        send_frame(8'h11, 1'b1, 0);
        idle(CPB);
        chk("t4_valid_held", int'(u_if.valid_out), 1);
        chk("t4_data_first", int'(u_if.data_out), 'h11);
        send_frame(8'h22, 1'b1, 0);
        idle(CPB);
        chk("t4_overrun", n_ov - o0, 1);
        chk("t4_data_kept", int'(u_if.data_out), 'h11);
        ready_pulse();
        chk("t4_valid_cleared", int'(u_if.valid_out), 0);
        chk("t4_data_after", int'(u_if.data_out), 'h11);

        // 5: back-to-back frames with no idle gap
        u_if.ready_in = 1'b1;
        l0 = n_loads; f0 = n_fe; o0 = n_ov;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(2 * CPB);
        chk("t5_loads", n_loads - l0, 2);
        chk("t5_data", int'(u_if.data_out), 'hFF);
        chk("t5_no_errors", (n_fe - f0) + (n_ov - o0), 0);

        // 6: reset mid-frame with the line held low across release
        u_if.rx_in = 1'b0;
        bit_wait();
        for (int i = 0; i < 4; i++) begin
            u_if.rx_in = c3[i];
            bit_wait();
        end
        chk("t6_busy_mid", int'(u_if.busy_out), 1);
        rst_n = 1'b0;
        u_if.rx_in = 1'b0;
        #1;
        chk("t6_busy_async", int'(u_if.busy_out), 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pending = 1'b0;
        l0 = n_loads; f0 = n_fe; o0 = n_ov;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_valid", int'(u_if.valid_out), 0);
        chk("t6_data", int'(u_if.data_out), 0);
        chk("t6_busy", int'(u_if.busy_out), 0);
        chk("t6_no_activity", (n_loads - l0) + (n_fe - f0) + (n_ov - o0), 0);
        idle(CPB);
        send_frame(8'h5A, 1'b1, 0);
        idle(2 * CPB);
        chk("t6_loads", n_loads - l0, 1);
        chk("t6_data_after", int'(u_if.data_out), 'h5A);

        // Random frames: random data, ready mode, gaps and occasional framing errors
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit         bad;
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            u_if.ready_in = 1'($urandom_range(0, 1));
            send_frame(b, !bad, bad ? int'($urandom_range(0, 2)) : 0);
            if (bad) begin
                idle(CPB * int'($urandom_range(1, 2)));
            end else begin
                if ($urandom_range(0, 2) == 0) ready_pulse();
                idle(CPB * int'($urandom_range(0, 2)));
            end
        end

        idle(100);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
